// File: rtl/usb_cmd_decoder.sv
// usb_cmd_decoder: pops host command packets from EP4, runs register writes/reads,
// and returns read responses on EP8; malformed or stalled packets are dropped and counted.
module usb_cmd_decoder #(
   parameter int          ADDR_W  = 8,
   parameter int          TIMEOUT = 1000,
   parameter logic [7:0]  SYNC    = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       cmd_fifo_data,
   input  logic              cmd_fifo_empty,
   output logic              cmd_fifo_re,
   output logic [15:0]       rsp_fifo_data,
   output logic              rsp_fifo_we,
   input  logic              rsp_fifo_full,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [15:0]       reg_wdata,
   output logic              reg_we,
   output logic              reg_re,
   input  logic [15:0]       reg_rdata,
   output logic              busy,
   output logic [7:0]        err_count
);
   typedef enum logic [3:0] {
      IDLE, GET_ADDR, GET_DATA, REG_WR, REG_RD, RD_WAIT, RSP_HDR, RSP_ADDR, RSP_DATA
   } state_t;

   state_t      state, next;
   logic        op_rd;
   logic [15:0] addr, rdata, tcnt;
   logic        getting, hdr_wr, hdr_rd, tmo, err_inc;

   assign reg_addr = addr[ADDR_W-1:0];

   always_comb begin
      getting       = state == GET_ADDR || state == GET_DATA;
      cmd_fifo_re   = !cmd_fifo_empty && (state == IDLE || getting);
      rsp_fifo_we   = !rsp_fifo_full && (state == RSP_HDR || state == RSP_ADDR || state == RSP_DATA);
      rsp_fifo_data = state == RSP_HDR  ? {SYNC, 8'h02} :
                      state == RSP_ADDR ? addr :
                      state == RSP_DATA ? rdata : 16'h0000;
      reg_we        = state == REG_WR;
      reg_re        = state == REG_RD;
      busy          = state != IDLE;
      hdr_wr        = cmd_fifo_data == {SYNC, 8'h01};
      hdr_rd        = cmd_fifo_data == {SYNC, 8'h02};
      // an empty FIFO is required, so a word arriving on the deadline cycle still wins
      tmo           = cmd_fifo_empty && tcnt == 16'(TIMEOUT);
      err_inc       = (state == IDLE && cmd_fifo_re && !hdr_wr && !hdr_rd) || (getting && tmo);
      next          = state;
      case (state)
         IDLE:     next = cmd_fifo_re && (hdr_wr || hdr_rd) ? GET_ADDR : IDLE;
         GET_ADDR: next = cmd_fifo_re ? (op_rd ? REG_RD : GET_DATA) : tmo ? IDLE : GET_ADDR;
         GET_DATA: next = cmd_fifo_re ? REG_WR : tmo ? IDLE : GET_DATA;
         REG_WR:   next = IDLE;
         REG_RD:   next = RD_WAIT;
         RD_WAIT:  next = RSP_HDR;
         RSP_HDR:  next = rsp_fifo_we ? RSP_ADDR : RSP_HDR;
         RSP_ADDR: next = rsp_fifo_we ? RSP_DATA : RSP_ADDR;
         RSP_DATA: next = rsp_fifo_we ? IDLE : RSP_DATA;
         default:  next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op_rd     <= 1'b0;
         addr      <= 16'h0000;
         reg_wdata <= 16'h0000;
         rdata     <= 16'h0000;
         tcnt      <= 16'h0000;
         err_count <= 8'h00;
      end else begin
         state <= next;
         if (state == IDLE && cmd_fifo_re)
            op_rd <= hdr_rd;
         if (state == GET_ADDR && cmd_fifo_re)
            addr <= cmd_fifo_data;
         if (state == GET_DATA && cmd_fifo_re)
            reg_wdata <= cmd_fifo_data;
         if (state == RD_WAIT)
            rdata <= reg_rdata;
         tcnt <= getting && next == state && !cmd_fifo_re ? tcnt + 16'd1 : 16'h0000;
         if (err_inc && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
      end
   end
endmodule

// File: tb/tb_usb_cmd_decoder.sv
// tb_usb_cmd_decoder: table vectors, timing sequences and a randomized stream
// checked against a packet-level parse of the same word stream.
module tb_usb_cmd_decoder;
   localparam int TO = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cmd_fifo_data;
   logic        cmd_fifo_empty;
   logic        cmd_fifo_re;
   logic [15:0] rsp_fifo_data;
   logic        rsp_fifo_we;
   logic        rsp_fifo_full;
   logic [7:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic        reg_we;
   logic        reg_re;
   logic [15:0] reg_rdata;
   logic        busy;
   logic [7:0]  err_count;

   always #5 clk = ~clk;

   usb_cmd_decoder #(.ADDR_W(8), .TIMEOUT(TO), .SYNC(8'hA5)) dut (
      .clk(clk), .rst(rst),
      .cmd_fifo_data(cmd_fifo_data), .cmd_fifo_empty(cmd_fifo_empty), .cmd_fifo_re(cmd_fifo_re),
      .rsp_fifo_data(rsp_fifo_data), .rsp_fifo_we(rsp_fifo_we), .rsp_fifo_full(rsp_fifo_full),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
      .reg_rdata(reg_rdata), .busy(busy), .err_count(err_count)
   );

   typedef struct {
      logic [15:0] w0, w1, w2;
      int          n, err, nwr, nrsp;
      logic [15:0] a, d;
   } vec_t;

   int checks = 0, failures = 0, cyc = 0, base = 0;
   int gap_pct = 0, full_pct = 0, gap_run = 0;
   bit hold_full = 0, hold_empty = 0, rd_pend = 0;
   logic [7:0]  rd_a;
   logic [15:0] slave_mem [256];
   logic [15:0] model_mem [256];
   logic [15:0] src[$], got_rsp[$], exp_rsp[$], data_q[$], stream[$];
   logic [23:0] got_wr[$], exp_wr[$];
   int pop_cyc[$], push_cyc[$], we_cyc[$], re_cyc[$], busy_q[$];
   logic [7:0] re_addr[$];
   vec_t tv [10];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int qi(int q[$], int i);
      return i < q.size() ? q[i] : -1;
   endfunction

   task automatic clear_logs();
      base = cyc;
      got_rsp.delete(); got_wr.delete(); data_q.delete();
      pop_cyc.delete(); push_cyc.delete(); we_cyc.delete(); re_cyc.delete();
      busy_q.delete(); re_addr.delete();
   endtask

   // one clock: drive inputs, observe the cycle, then apply the register slave's read data
   task automatic tick();
      bit stall;
      stall = hold_empty || (src.size() > 0 && gap_run < 5 && $urandom_range(99) < gap_pct);
      gap_run = stall ? gap_run + 1 : 0;
      cmd_fifo_empty = src.size() == 0 || stall;
      cmd_fifo_data  = src.size() > 0 ? src[0] : 16'h0000;
      rsp_fifo_full  = hold_full || ($urandom_range(99) < full_pct);
      #1;
      chk("re_we_exclusive", {31'd0, cmd_fifo_re && rsp_fifo_we}, 0);
      chk("no_push_when_full", {31'd0, rsp_fifo_full && rsp_fifo_we}, 0);
      chk("no_pop_when_empty", {31'd0, cmd_fifo_empty && cmd_fifo_re}, 0);
      if (cmd_fifo_re) begin
         void'(src.pop_front());
         pop_cyc.push_back(cyc - base);
      end
      if (rsp_fifo_we) begin
         got_rsp.push_back(rsp_fifo_data);
         push_cyc.push_back(cyc - base);
      end
      if (reg_we) begin
         got_wr.push_back({reg_addr, reg_wdata});
         we_cyc.push_back(cyc - base);
         slave_mem[reg_addr] = reg_wdata;
      end
      if (reg_re) begin
         re_cyc.push_back(cyc - base);
         re_addr.push_back(reg_addr);
      end
      rd_pend = reg_re;
      rd_a    = reg_addr;
      busy_q.push_back(int'(busy));
      data_q.push_back(rsp_fifo_data);
      @(posedge clk);
      cyc++;
      #1;
      reg_rdata = rd_pend ? slave_mem[rd_a] : 16'($urandom);
   endtask

   task automatic run_idle(int budget);
      int n = 0;
      do begin
         tick();
         n++;
      end while ((src.size() > 0 || busy) && n < budget);
      chk("idle_within_budget", {31'd0, src.size() > 0 || busy}, 0);
      tick();
      tick();
   endtask

   initial begin
      int e0, p, merr, i, r, na;
      logic [15:0] a, d, g;
      rst = 1; cmd_fifo_empty = 1; cmd_fifo_data = 0; rsp_fifo_full = 0; reg_rdata = 0;
      for (int k = 0; k < 256; k++) slave_mem[k] = 16'(k * 16'h0101) ^ 16'h3C3C;
      tv[0] = '{16'hA501, 16'h0012, 16'hBEEF, 3, 0, 1, 0, 16'h0012, 16'hBEEF};
      tv[1] = '{16'hA502, 16'h0012, 16'h0000, 2, 0, 0, 3, 16'h0012, 16'hBEEF};
      tv[2] = '{16'h1234, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000, 16'h0000};
      tv[3] = '{16'hA5FF, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000, 16'h0000};
      tv[4] = '{16'hA501, 16'hFF34, 16'h1111, 3, 0, 1, 0, 16'hFF34, 16'h1111};
      tv[5] = '{16'hA502, 16'hAB34, 16'h0000, 2, 0, 0, 3, 16'hAB34, 16'h1111};
      tv[6] = '{16'hA503, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000, 16'h0000};
      tv[7] = '{16'h5A01, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000, 16'h0000};
      tv[8] = '{16'hA500, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000, 16'h0000};
      tv[9] = '{16'hA501, 16'h0000, 16'h0000, 3, 0, 1, 0, 16'h0000, 16'h0000};
      @(posedge clk); #1;
      repeat (3) tick();
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_err", {24'd0, err_count}, 0);
      chk("rst_reg_addr", {24'd0, reg_addr}, 0);
      chk("rst_wdata", {16'd0, reg_wdata}, 0);
      chk("rst_rsp_data", {16'd0, rsp_fifo_data}, 0);
      chk("rst_strobes", {30'd0, reg_we, reg_re}, 0);
      rst = 0;

      for (int v = 0; v < 10; v++) begin
         clear_logs();
         e0 = err_count;
         src.push_back(tv[v].w0);
         if (tv[v].n > 1) src.push_back(tv[v].w1);
         if (tv[v].n > 2) src.push_back(tv[v].w2);
         run_idle(200);
         chk($sformatf("vec%0d_err", v), 32'(int'(err_count) - e0), 32'(tv[v].err));
         chk($sformatf("vec%0d_nwr", v), 32'(got_wr.size()), 32'(tv[v].nwr));
         chk($sformatf("vec%0d_nrsp", v), 32'(got_rsp.size()), 32'(tv[v].nrsp));
         if (tv[v].nwr > 0 && got_wr.size() > 0)
            chk($sformatf("vec%0d_wr", v), {8'd0, got_wr[0]}, {8'd0, tv[v].a[7:0], tv[v].d});
         if (tv[v].nrsp == 3 && got_rsp.size() == 3) begin
            chk($sformatf("vec%0d_rsp0", v), {16'd0, got_rsp[0]}, 32'hA502);
            chk($sformatf("vec%0d_rsp1", v), {16'd0, got_rsp[1]}, {16'd0, tv[v].a});
            chk($sformatf("vec%0d_rsp2", v), {16'd0, got_rsp[2]}, {16'd0, tv[v].d});
         end
      end

      // write timing: reg_we three cycles after header pop
      clear_logs();
      src.push_back(16'hA501); src.push_back(16'h0012); src.push_back(16'hBEEF);
      run_idle(100);
      p = qi(pop_cyc, 0);
      chk("wr_we_count", 32'(we_cyc.size()), 1);
      chk("wr_we_delay", 32'(qi(we_cyc, 0) - p), 3);
      chk("wr_next_pop_idle", 32'(qi(busy_q, p + 4)), 0);
      chk("wr_no_push", 32'(got_rsp.size()), 0);

      // read timing: reg_re at +2, pushes at +4..+6, busy low at +7
      clear_logs();
      slave_mem[8'h34] = 16'h5A5A;
      src.push_back(16'hA502); src.push_back(16'h0134);
      run_idle(100);
      p = qi(pop_cyc, 0);
      chk("rd_re_delay", 32'(qi(re_cyc, 0) - p), 2);
      chk("rd_re_addr", re_addr.size() > 0 ? {24'd0, re_addr[0]} : 32'hFFFF_FFFF, 32'h34);
      for (int k = 0; k < 3; k++)
         chk($sformatf("rd_push%0d_cycle", k), 32'(qi(push_cyc, k) - p), 32'(4 + k));
      chk("rd_busy_c6", 32'(qi(busy_q, p + 6)), 1);
      chk("rd_busy_c7", 32'(qi(busy_q, p + 7)), 0);
      chk("rd_nrsp", 32'(got_rsp.size()), 3);
      if (got_rsp.size() == 3) begin
         chk("rd_rsp0", {16'd0, got_rsp[0]}, 32'hA502);
         chk("rd_rsp1", {16'd0, got_rsp[1]}, 32'h0134);
         chk("rd_rsp2", {16'd0, got_rsp[2]}, 32'h5A5A);
      end

      // timeout after a lone header, then late data word is a bad header
      clear_logs();
      e0 = err_count;
      src.push_back(16'hA501);
      run_idle(TO + 50);
      chk("tmo_err", 32'(int'(err_count) - e0), 1);
      na = 0;
      foreach (busy_q[k]) na += busy_q[k];
      chk("tmo_busy_cycles", 32'(na), 32'(TO + 1));
      clear_logs();
      src.push_back(16'hBEEF);
      src.push_back(16'hA501); src.push_back(16'h0056); src.push_back(16'hCAFE);
      run_idle(100);
      chk("tmo_late_err", 32'(int'(err_count) - e0), 2);
      chk("tmo_after_wr", got_wr.size() == 1 ? {8'd0, got_wr[0]} : 32'hFFFF_FFFF, 32'h0056CAFE);

      // a word landing exactly on the deadline cycle is accepted
      clear_logs();
      e0 = err_count;
      src.push_back(16'hA501);
      tick();
      hold_empty = 1;
      src.push_back(16'h0078); src.push_back(16'hDEAD);
      repeat (TO) tick();
      hold_empty = 0;
      run_idle(100);
      chk("deadline_err", 32'(int'(err_count) - e0), 0);
      chk("deadline_wr", got_wr.size() == 1 ? {8'd0, got_wr[0]} : 32'hFFFF_FFFF, 32'h0078DEAD);

      // backpressure held for 5 cycles at RSP_ADDR
      clear_logs();
      slave_mem[8'h99] = 16'h7777;
      src.push_back(16'hA502); src.push_back(16'h0199);
      na = 0;
      while (push_cyc.size() == 0 && na < 50) begin tick(); na++; end
      hold_full = 1;
      repeat (5) tick();
      hold_full = 0;
      chk("bp_no_push_full", 32'(push_cyc.size()), 1);
      for (int k = 0; k < 5; k++)
         chk("bp_addr_hold", {16'd0, data_q[data_q.size() - 1 - k]}, 32'h0199);
      run_idle(100);
      chk("bp_nrsp", 32'(got_rsp.size()), 3);
      if (got_rsp.size() == 3) begin
         chk("bp_rsp0", {16'd0, got_rsp[0]}, 32'hA502);
         chk("bp_rsp1", {16'd0, got_rsp[1]}, 32'h0199);
         chk("bp_rsp2", {16'd0, got_rsp[2]}, 32'h7777);
      end

      // randomized stream against a packet-level parse
      for (int k = 0; k < 256; k++) begin
         slave_mem[k] = 16'($urandom);
         model_mem[k] = slave_mem[k];
      end
      stream.delete(); exp_rsp.delete(); exp_wr.delete();
      for (int k = 0; k < 150; k++) begin
         r = $urandom_range(9);
         a = 16'($urandom); d = 16'($urandom);
         if (r < 4) begin
            stream.push_back(16'hA501); stream.push_back(a); stream.push_back(d);
         end else if (r < 8) begin
            stream.push_back(16'hA502); stream.push_back(a);
         end else begin
            g = 16'($urandom);
            if (g == 16'hA501 || g == 16'hA502) g = 16'hA57E;
            stream.push_back(g);
         end
      end
      merr = 0; i = 0;
      while (i < stream.size()) begin
         if (stream[i] == 16'hA501) begin
            exp_wr.push_back({stream[i + 1][7:0], stream[i + 2]});
            model_mem[stream[i + 1][7:0]] = stream[i + 2];
            i += 3;
         end else if (stream[i] == 16'hA502) begin
            exp_rsp.push_back(16'hA502);
            exp_rsp.push_back(stream[i + 1]);
            exp_rsp.push_back(model_mem[stream[i + 1][7:0]]);
            i += 2;
         end else begin
            merr++;
            i++;
         end
      end
      clear_logs();
      e0 = err_count;
      src = stream;
      gap_pct = 30; full_pct = 30;
      run_idle(20000);
      gap_pct = 0; full_pct = 0;
      chk("rand_nwr", 32'(got_wr.size()), 32'(exp_wr.size()));
      chk("rand_nrsp", 32'(got_rsp.size()), 32'(exp_rsp.size()));
      foreach (exp_wr[k])
         chk("rand_wr", k < got_wr.size() ? {8'd0, got_wr[k]} : 32'hFFFF_FFFF, {8'd0, exp_wr[k]});
      foreach (exp_rsp[k])
         chk("rand_rsp", k < got_rsp.size() ? {16'd0, got_rsp[k]} : 32'hFFFF_FFFF, {16'd0, exp_rsp[k]});
      chk("rand_err", {24'd0, err_count}, 32'((e0 + merr) > 255 ? 255 : e0 + merr));

      // error counter saturation
      repeat (300) src.push_back(16'h0000);
      run_idle(1000);
      chk("err_saturate", {24'd0, err_count}, 32'hFF);

      // reset while waiting in GET_DATA
      clear_logs();
      src.push_back(16'hA501); src.push_back(16'h0056);
      repeat (3) tick();
      chk("pre_rst_busy", {31'd0, busy}, 1);
      rst = 1;
      tick();
      rst = 0;
      chk("mid_rst_busy", {31'd0, busy}, 0);
      chk("mid_rst_err", {24'd0, err_count}, 0);
      chk("mid_rst_reg_addr", {24'd0, reg_addr}, 0);
      chk("mid_rst_wdata", {16'd0, reg_wdata}, 0);
      chk("mid_rst_rsp_data", {16'd0, rsp_fifo_data}, 0);
      chk("mid_rst_strobes", {30'd0, reg_we, reg_re}, 0);
      chk("mid_rst_no_we", 32'(we_cyc.size()), 0);
      src.push_back(16'hA501); src.push_back(16'h0057); src.push_back(16'h4321);
      run_idle(100);
      chk("post_rst_wr", got_wr.size() == 1 ? {8'd0, got_wr[0]} : 32'hFFFF_FFFF, 32'h00574321);
      chk("post_rst_err", {24'd0, err_count}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/usb_cmd_decoder.md
# usb_cmd_decoder

Register-access command decoder sitting directly downstream of the USB slave-FIFO interface's command/status path, in the `FIFO_CLOCK` (IFCLK) domain. It pops host command packets from the EP4 command FIFO, performs register writes and reads on a simple local register bus, and pushes read responses into the EP8 status FIFO for return to the host. Malformed or stalled packets are dropped and counted; the block always resynchronises on the next valid header.

## Interface
- `ADDR_W`, 8, number of low address-word bits driven onto `reg_addr`; the upper bits are ignored.
- `TIMEOUT`, 1000, idle cycles allowed mid-packet before abort; range 1..65535.
- `SYNC`, 8'hA5, required value of header bits [15:8].

Ports:
- `clk` in 1: the only clock, connected to `FIFO_CLOCK`.
- `rst` in 1: reset, synchronous and active-high.
- `cmd_fifo_data` in 16: EP4 FIFO head word; first-word-fall-through, valid whenever `!cmd_fifo_empty`.
- `cmd_fifo_empty` in 1: EP4 FIFO empty.
- `cmd_fifo_re` out 1: pop the current head word.
- `rsp_fifo_data` out 16: word to EP8 FIFO.
- `rsp_fifo_we` out 1: push `rsp_fifo_data`.
- `rsp_fifo_full` in 1: EP8 FIFO full.
- `reg_addr` out ADDR_W: register address.
- `reg_wdata` out 16: write data.
- `reg_we` out 1: one-cycle write strobe.
- `reg_re` out 1: one-cycle read strobe.
- `reg_rdata` in 16: read data, valid exactly one cycle after `reg_re`.
- `busy` out 1: high whenever the state is not IDLE.
- `err_count` out 8: saturating count of dropped packets.

## Operation
- Packet format, in 16-bit words:
  - Word 0 is the header `{SYNC, opcode}`.
  - Opcode 8'h01 is WRITE: header, addr, data.
  - Opcode 8'h02 is READ: header, addr.
- A READ response is 3 words pushed to EP8: `{SYNC,8'h02}`, addr (full 16-bit echo), data.
- A WRITE produces no response.
- States: IDLE, GET_ADDR, GET_DATA, REG_WR, REG_RD, RD_WAIT, RSP_HDR, RSP_ADDR, RSP_DATA.
- `cmd_fifo_re = !cmd_fifo_empty && state∈{IDLE,GET_ADDR,GET_DATA}`. This is combinational from registered state; the word is consumed in the same cycle.
- IDLE, on pop:
  - Valid WRITE header → GET_ADDR, op latched as write.
  - Valid READ header → GET_ADDR, op latched as read.
  - Wrong SYNC or unknown opcode → word discarded, `err_count`+1, stay IDLE.
- GET_ADDR, on pop: latch addr; write → GET_DATA; read → REG_RD.
- GET_DATA, on pop: latch data → REG_WR.
- REG_WR: `reg_we`=1 for this one cycle with `reg_addr`/`reg_wdata` stable → IDLE.
- REG_RD: `reg_re`=1 for one cycle → RD_WAIT.
- RD_WAIT: capture `reg_rdata` → RSP_HDR.
- RSP_HDR, RSP_ADDR, RSP_DATA: `rsp_fifo_we = !rsp_fifo_full`. On a push, advance; RSP_DATA → IDLE. While full, the state and `rsp_fifo_data` hold, with no timeout.
- Timeout:
  - A 16-bit counter runs in GET_ADDR and GET_DATA and clears on every pop and on state entry.
  - When it reaches `TIMEOUT` with the FIFO still empty → IDLE, `err_count`+1, packet discarded.
  - A word arriving in the same cycle the counter hits `TIMEOUT` is popped and accepted; the pop wins.
- `err_count` saturates at 255 and never wraps.
- Reset, including mid-packet: state IDLE and every output 0 (`reg_addr`, `reg_wdata`, `rsp_fifo_data`, strobes, `busy`, `err_count`). Partial packets are lost, and words already popped are not restored.

## Timing
- `reg_addr`, `reg_wdata`, `rsp_fifo_data`, `reg_we`, `reg_re` and `busy` are registered (or decoded from registered state). `cmd_fifo_re` and `rsp_fifo_we` are combinational on the FIFO flag inputs.
- WRITE with back-to-back words: header popped cycle 0, addr cycle 1, data cycle 2, `reg_we` cycle 3, IDLE cycle 4. The next header can be popped in cycle 4.
- READ with no backpressure:
  - Header popped cycle 0, addr cycle 1.
  - `reg_re` cycle 2, `reg_rdata` sampled cycle 3.
  - Response words pushed cycles 4, 5, 6; IDLE cycle 7.
- Every full cycle on EP8 adds one cycle per word.
- At most one word is popped and at most one word is pushed per cycle.
- `cmd_fifo_re` and `rsp_fifo_we` are never both asserted.

## Test plan
- WRITE sequence:
  - Stimulus: A501, 0012, BEEF queued.
  - Required: `reg_we` for exactly one cycle, 3 cycles after the header pop, with `reg_addr`=8'h12 and `reg_wdata`=16'hBEEF.
  - Required: no EP8 push and `err_count`=0.
- READ sequence:
  - Stimulus: A502, 0134 queued; `reg_rdata`=16'h5A5A in the cycle after `reg_re`.
  - Required: `reg_addr`=8'h34.
  - Required: EP8 receives A502, 0134, 5A5A on cycles 4–6, and `busy` falls on cycle 7.
- Garbage then valid:
  - Stimulus: 1234, A5FF, then a valid WRITE.
  - Required: `err_count`=2, and the WRITE executes normally.
- Timeout:
  - Stimulus: header A501 only, FIFO then empty for `TIMEOUT` cycles.
  - Required: return to IDLE and `err_count`+1.
  - Required: a subsequent complete WRITE executes, with the late data word treated as a new header (error).
- Backpressure:
  - Stimulus: READ with `rsp_fifo_full` high for 5 cycles at RSP_ADDR.
  - Required: the addr word is held stable, no `rsp_fifo_we` while full, and all 3 words are delivered in order with none duplicated.
- Reset mid-packet:
  - Stimulus: `rst` asserted in GET_DATA.
  - Required: next cycle all outputs are 0 and the state is IDLE, with no `reg_we`; the following packet decodes correctly.
